// File: rtl/iserdes2_pkg.sv
// Shared definitions for the ISERDES2 word-alignment trainer: lane FSM
// states, default training pattern and error-counter helpers.
package iserdes2_pkg;

  // Per-lane training FSM states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_SLIP   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_LOCKED = 3'd4,
    ST_FAIL   = 3'd5
  } lane_state_e;

  localparam logic [7:0] TRAIN_PATTERN_DEFAULT = 8'h0F;
  localparam int         ERR_CNT_WIDTH         = 16;

  // Saturating increment for the post-lock error counters
  function automatic logic [ERR_CNT_WIDTH-1:0] err_sat_inc(input logic [ERR_CNT_WIDTH-1:0] value);
    logic [ERR_CNT_WIDTH-1:0] result;
    if (value == {ERR_CNT_WIDTH{1'b1}}) begin
      result = value;
    end else begin
      result = value + {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};
    end
    return result;
  endfunction

endpackage

// File: rtl/iserdes2_lane_align.sv
// One lane of the word-alignment trainer: compares the lane word against the
// training pattern, pulses bitslip until it holds, then reports lock or fail.
// Optional post-lock error counter built when ISERDES2_WORD_ALIGN_ERRCNT_EN is defined.
module iserdes2_lane_align
  import iserdes2_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 8,
  parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = DATA_WIDTH'(TRAIN_PATTERN_DEFAULT),
  parameter int                    MATCH_COUNT   = 16,
  parameter int                    SETTLE_CYCLES = 4,
  parameter int                    MAX_SLIPS     = DATA_WIDTH
) (
  input  logic                     clkdiv,
  input  logic                     reset_n,
  input  logic                     train_start,
  input  logic [DATA_WIDTH-1:0]    lane_word,
  output logic                     bitslip,
  output logic                     locked,
  output logic                     fail,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

  localparam int MATCH_W  = $clog2(MATCH_COUNT + 1);
  localparam int SLIP_W   = $clog2(MAX_SLIPS + 1);
  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);

  lane_state_e         state_r;
  logic [MATCH_W-1:0]  match_cnt_r;
  logic [SLIP_W-1:0]   slip_cnt_r;
  logic [SETTLE_W-1:0] settle_cnt_r;
  logic                bitslip_r;
  logic                locked_r;
  logic                fail_r;
  logic                match_s;

  assign match_s = (lane_word == TRAIN_PATTERN);

  // Lane training FSM with its counters and registered decoded outputs
  always_ff @(posedge clkdiv or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      match_cnt_r  <= {MATCH_W{1'b0}};
      slip_cnt_r   <= {SLIP_W{1'b0}};
      settle_cnt_r <= {SETTLE_W{1'b0}};
      bitslip_r    <= 1'b0;
      locked_r     <= 1'b0;
      fail_r       <= 1'b0;
    end else if (train_start) begin
      state_r      <= ST_CHECK;
      match_cnt_r  <= {MATCH_W{1'b0}};
      slip_cnt_r   <= {SLIP_W{1'b0}};
      settle_cnt_r <= {SETTLE_W{1'b0}};
      bitslip_r    <= 1'b0;
      locked_r     <= 1'b0;
      fail_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r <= ST_IDLE;
        end
        ST_CHECK: begin
          if (match_s) begin
            match_cnt_r <= match_cnt_r + MATCH_W'(1);
            if (match_cnt_r == MATCH_W'(MATCH_COUNT - 1)) begin
              state_r  <= ST_LOCKED;
              locked_r <= 1'b1;
            end else begin
              state_r <= ST_CHECK;
            end
          end else if (slip_cnt_r == SLIP_W'(MAX_SLIPS)) begin
            state_r <= ST_FAIL;
            fail_r  <= 1'b1;
          end else begin
            state_r   <= ST_SLIP;
            bitslip_r <= 1'b1;
          end
        end
        ST_SLIP: begin
          // Slip count stops at MAX_SLIPS because CHECK fails the lane there
          slip_cnt_r   <= slip_cnt_r + SLIP_W'(1);
          settle_cnt_r <= {SETTLE_W{1'b0}};
          bitslip_r    <= 1'b0;
          state_r      <= ST_SETTLE;
        end
        ST_SETTLE: begin
          match_cnt_r <= {MATCH_W{1'b0}};
          if (settle_cnt_r == SETTLE_W'(SETTLE_CYCLES - 1)) begin
            state_r <= ST_CHECK;
          end else begin
            settle_cnt_r <= settle_cnt_r + SETTLE_W'(1);
          end
        end
        ST_LOCKED: begin
          state_r <= ST_LOCKED;
        end
        ST_FAIL: begin
          state_r <= ST_FAIL;
        end
        default: begin
          state_r   <= ST_IDLE;
          bitslip_r <= 1'b0;
          locked_r  <= 1'b0;
          fail_r    <= 1'b0;
        end
      endcase
    end
  end

  assign bitslip = bitslip_r;
  assign locked  = locked_r;
  assign fail    = fail_r;

`ifdef ISERDES2_WORD_ALIGN_ERRCNT_EN
  logic [ERR_CNT_WIDTH-1:0] err_cnt_r;

  // Saturating count of pattern mismatches seen while locked
  always_ff @(posedge clkdiv or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt_r <= {ERR_CNT_WIDTH{1'b0}};
    end else if (train_start) begin
      err_cnt_r <= {ERR_CNT_WIDTH{1'b0}};
    end else if ((state_r == ST_LOCKED) && !match_s) begin
      err_cnt_r <= err_sat_inc(err_cnt_r);
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign err_cnt = err_cnt_r;
`else
  assign err_cnt = {ERR_CNT_WIDTH{1'b0}};
`endif

endmodule

// File: rtl/iserdes2_word_align.sv
// Two-lane word-alignment trainer sitting behind the ISERDES2 PHY. Lane A is
// din[7:0], lane B is din[15:8]; each lane trains independently.
// Optional feature macro: ISERDES2_WORD_ALIGN_ERRCNT_EN (post-lock error counters).
module iserdes2_word_align
  import iserdes2_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 8,
  parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = DATA_WIDTH'(TRAIN_PATTERN_DEFAULT),
  parameter int                    MATCH_COUNT   = 16,
  parameter int                    SETTLE_CYCLES = 4,
  parameter int                    MAX_SLIPS     = DATA_WIDTH
) (
  input  logic                      clkdiv,
  input  logic                      reset_n,
  input  logic                      train_start,
  input  logic [2*DATA_WIDTH-1:0]   din,
  output logic                      bitslip_a,
  output logic                      bitslip_b,
  output logic                      locked_a,
  output logic                      locked_b,
  output logic                      fail_a,
  output logic                      fail_b,
  output logic                      done,
  output logic [2*DATA_WIDTH-1:0]   dout,
  output logic                      dout_valid,
  output logic [ERR_CNT_WIDTH-1:0]  err_cnt_a,
  output logic [ERR_CNT_WIDTH-1:0]  err_cnt_b
);

  logic [2*DATA_WIDTH-1:0] dout_r;

  iserdes2_lane_align #(
    .DATA_WIDTH    (DATA_WIDTH),
    .TRAIN_PATTERN (TRAIN_PATTERN),
    .MATCH_COUNT   (MATCH_COUNT),
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .MAX_SLIPS     (MAX_SLIPS)
  ) u_lane_a (
    .clkdiv      (clkdiv),
    .reset_n     (reset_n),
    .train_start (train_start),
    .lane_word   (din[DATA_WIDTH-1:0]),
    .bitslip     (bitslip_a),
    .locked      (locked_a),
    .fail        (fail_a),
    .err_cnt     (err_cnt_a)
  );

  iserdes2_lane_align #(
    .DATA_WIDTH    (DATA_WIDTH),
    .TRAIN_PATTERN (TRAIN_PATTERN),
    .MATCH_COUNT   (MATCH_COUNT),
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .MAX_SLIPS     (MAX_SLIPS)
  ) u_lane_b (
    .clkdiv      (clkdiv),
    .reset_n     (reset_n),
    .train_start (train_start),
    .lane_word   (din[2*DATA_WIDTH-1:DATA_WIDTH]),
    .bitslip     (bitslip_b),
    .locked      (locked_b),
    .fail        (fail_b),
    .err_cnt     (err_cnt_b)
  );

  // Forward PHY data every cycle, independent of lock state
  always_ff @(posedge clkdiv or negedge reset_n) begin
    if (!reset_n) begin
      dout_r <= {(2*DATA_WIDTH){1'b0}};
    end else begin
      dout_r <= din;
    end
  end

  assign dout = dout_r;

  // Both terms are register outputs, so these stay glitch-free
  assign done       = (locked_a | fail_a) & (locked_b | fail_b);
  assign dout_valid = locked_a & locked_b;

endmodule
